mux_n_stream_rr: RTL

- Parametrised N-channel, W-bit streaming multiplexer with valid/ready handshakes on every input and on the output.
- Two selection modes:
  - fixed: the external sel port chooses the channel.
  - round-robin: fair rotation among valid channels.
- The selected word is captured in a one-entry output register, giving one cycle of latency and full throughput.
- Generalises the 4:1 combinational select into a registered, flow-controlled funnel for merging producer streams.

---
 rtl/mux_n_stream_rr_if.sv | 27 ++
 rtl/mux_n_stream_rr.sv | 84 ++++++++
 2 files changed

// File: rtl/mux_n_stream_rr_if.sv
// Handshake bundle for the N-channel stream funnel: per-channel inputs,
// mode/sel controls and the registered output stream.
interface mux_n_stream_rr_if #(
  parameter int unsigned N     = 4,
  parameter int unsigned W     = 8,
  parameter int unsigned SEL_W = 2
);
  logic [N*W-1:0]   in_data;
  logic [N-1:0]     in_valid;
  logic [N-1:0]     in_ready;
  logic             mode;
  logic [SEL_W-1:0] sel;
  logic [W-1:0]     out_data;
  logic             out_valid;
  logic             out_ready;
  logic [SEL_W-1:0] out_chan;

  modport master (
    output in_data, in_valid, mode, sel, out_ready,
    input  in_ready, out_data, out_valid, out_chan
  );

  modport slave (
    input  in_data, in_valid, mode, sel, out_ready,
    output in_ready, out_data, out_valid, out_chan
  );
endinterface

// File: rtl/mux_n_stream_rr.sv
// N-channel valid/ready stream multiplexer with fixed or round-robin
// selection and a one-entry registered output stage.
module mux_n_stream_rr #(
  parameter int unsigned N     = 4,
  parameter int unsigned W     = 8,
  parameter int unsigned SEL_W = 2
) (
  input  logic                clk,
  input  logic                reset,
  mux_n_stream_rr_if.slave    bus
);
  localparam int unsigned SW1 = SEL_W + 1;

  logic [SEL_W-1:0] ptr;
  logic [W-1:0]     data_q;
  logic [SEL_W-1:0] chan_q;
  logic             valid_q;

  logic             load;
  logic             granted;
  logic [SEL_W-1:0] grant;
  logic [SW1-1:0]   sum;
  logic [N-1:0]     ready_c;
  logic [W-1:0]     sel_data;
  logic             xfer;

  assign load = !valid_q || bus.out_ready;

  // Grant: fixed index in mode 0, first valid channel at or after ptr in mode 1.
  always_comb begin
    granted = 1'b0;
    grant   = '0;
    sum     = '0;
    if (!bus.mode) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (bus.sel == SEL_W'(i) && bus.in_valid[i]) begin
          granted = 1'b1;
          grant   = SEL_W'(i);
        end
      end
    end else begin
      for (int unsigned k = 0; k < N; k++) begin
        sum = {1'b0, ptr} + SW1'(k);
        if (sum >= SW1'(N)) sum = sum - SW1'(N);
        if (!granted && bus.in_valid[sum[SEL_W-1:0]]) begin
          granted = 1'b1;
          grant   = sum[SEL_W-1:0];
        end
      end
    end
  end

  always_comb begin
    ready_c  = '0;
    sel_data = '0;
    for (int unsigned i = 0; i < N; i++) begin
      ready_c[i] = !reset && load && granted && (grant == SEL_W'(i));
      if (grant == SEL_W'(i)) sel_data = bus.in_data[i*W +: W];
    end
  end

  assign xfer = |ready_c;

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr     <= '0;
      data_q  <= '0;
      chan_q  <= '0;
      valid_q <= 1'b0;
    end else if (xfer) begin
      data_q  <= sel_data;
      chan_q  <= grant;
      valid_q <= 1'b1;
      if (bus.mode) ptr <= (grant == SEL_W'(N - 1)) ? '0 : grant + SEL_W'(1);
    end else if (bus.out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign bus.in_ready  = ready_c;
  assign bus.out_data  = data_q;
  assign bus.out_chan  = chan_q;
  assign bus.out_valid = valid_q;
endmodule
